// File: rtl/alu_pkg.sv
// Shared ALU definitions: ALUControl encoding, FSM states and the shift-op helper.
// Combinational only; adds no latency and no flow control.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_AND     = 4'b0000,
    ALU_OR      = 4'b0001,
    ALU_ADD     = 4'b0010,
    ALU_XOR     = 4'b0100,
    ALU_SUB     = 4'b0110,
    ALU_SLT     = 4'b0111,
    ALU_SLTU    = 4'b1000,
    ALU_SLL     = 4'b1010,
    ALU_SRL     = 4'b1011,
    ALU_SRA     = 4'b1100,
    ALU_ILLEGAL = 4'b1111
  } alu_ctrl_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } alu_state_t;

  function automatic logic is_shift(input logic [3:0] op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_comb.sv
// Single-cycle ALU ops plus the legal-code check; purely combinational, no backpressure.
// Shift codes pass src a through unchanged (the shamt-0 result); anything unknown is illegal.
module alu_comb
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res,
  output logic             illegal
);

  always_comb begin
    res     = '0;
    illegal = 1'b0;
    case (op)
      ALU_AND:  res = a & b;
      ALU_OR:   res = a | b;
      ALU_ADD:  res = a + b;
      ALU_XOR:  res = a ^ b;
      ALU_SUB:  res = a - b;
      ALU_SLT:  res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: res = {{(WIDTH-1){1'b0}}, (a < b)};
      ALU_SLL, ALU_SRL, ALU_SRA: res = a;
      default:  illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_iter.sv
// Multi-cycle ALU: 1 cycle for logic/arith/compare, 1+n cycles for shifts by n (1 bit per cycle).
// in_ready is low while shifting or holding a result; the result holds until out_ready.
module alu_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_control,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

  localparam int SW = $clog2(WIDTH);

  alu_state_t       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shift_nxt, comb_res, result_q;
  logic [SW-1:0]    cnt_q, shamt;
  logic [3:0]       op_q;
  logic             fill_q, zero_q, illegal_q, comb_ill;
  logic             accept, start_shift, shift_last;

  assign shamt       = src_b[SW-1:0];
  assign accept      = in_valid && in_ready;
  assign start_shift = is_shift(alu_control) && (shamt != '0);
  assign shift_last  = (cnt_q == SW'(1));

  assign result  = result_q;
  assign zero    = zero_q;
  assign illegal = illegal_q;

  alu_comb #(.WIDTH(WIDTH)) u_comb (
    .op      (alu_control),
    .a       (src_a),
    .b       (src_b),
    .res     (comb_res),
    .illegal (comb_ill)
  );

  // sra fills with the operand's original sign bit, latched at accept
  always_comb begin
    shift_nxt = {fill_q, shreg_q[WIDTH-1:1]};
    case (op_q)
      ALU_SLL: shift_nxt = {shreg_q[WIDTH-2:0], 1'b0};
      ALU_SRL: shift_nxt = {1'b0, shreg_q[WIDTH-1:1]};
      default: shift_nxt = {fill_q, shreg_q[WIDTH-1:1]};
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = start_shift ? ST_SHIFT : ST_DONE;
      end
      ST_SHIFT: begin
        if (shift_last) state_d = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg_q   <= '0;
      cnt_q     <= '0;
      op_q      <= 4'b0000;
      fill_q    <= 1'b0;
      result_q  <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else if (accept) begin
      if (start_shift) begin
        shreg_q <= src_a;
        cnt_q   <= shamt;
        op_q    <= alu_control;
        fill_q  <= src_a[WIDTH-1];
      end else begin
        result_q  <= comb_res;
        zero_q    <= (comb_res == '0);
        illegal_q <= comb_ill;
      end
    end else if (state_q == ST_SHIFT) begin
      shreg_q <= shift_nxt;
      cnt_q   <= cnt_q - 1'b1;
      if (shift_last) begin
        result_q  <= shift_nxt;
        zero_q    <= (shift_nxt == '0);
        illegal_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_iter.sv
// Bench for alu_iter: directed vector table, hand-written reset/backpressure sequences,
// and randomized ops against a plain-arithmetic reference model.
module tb_alu_iter;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_control;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        illegal;

  int nchk  = 0;
  int nfail = 0;

  alu_iter #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .alu_control (alu_control),
    .src_a       (src_a),
    .src_b       (src_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .zero        (zero),
    .illegal     (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  typedef struct {
    logic [3:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        zero;
    logic        ill;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, got, exp);
    end
  endtask

  function automatic logic ref_ill(input logic [3:0] c);
    return !(c inside {4'd0, 4'd1, 4'd2, 4'd4, 4'd6, 4'd7, 4'd8, 4'd10, 4'd11, 4'd12});
  endfunction

  function automatic logic [31:0] ref_res(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    int sh;
    sh = int'(b % 32);
    case (c)
      4'd0:    return a & b;
      4'd1:    return a | b;
      4'd2:    return a + b;
      4'd4:    return a ^ b;
      4'd6:    return a - b;
      4'd7:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd8:    return (a < b) ? 32'd1 : 32'd0;
      4'd10:   return a << sh;
      4'd11:   return a >> sh;
      4'd12:   return 32'($signed(a) >>> sh);
      default: return 32'd0;
    endcase
  endfunction

  function automatic int ref_lat(input logic [3:0] c, input logic [31:0] b);
    if (c inside {4'd10, 4'd11, 4'd12}) return 1 + int'(b % 32);
    return 1;
  endfunction

  // Present one op in the cycle after the next falling edge; operands are scrambled after accept.
  task automatic send(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    check("in_ready at issue", {31'd0, in_ready}, 32'd1);
    in_valid    = 1'b1;
    alu_control = c;
    src_a       = a;
    src_b       = b;
    @(posedge clk);
    #1;
    in_valid    = 1'b0;
    src_a       = $urandom;
    src_b       = $urandom;
    alu_control = 4'($urandom);
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 40);
  endtask

  task automatic run_and_check(input string name, input logic [3:0] c, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] er, input logic ez,
                               input logic ei, input int el);
    int lat;
    send(c, a, b);
    wait_valid(lat);
    check({name, " latency"}, 32'(lat), 32'(el));
    check({name, " result"}, result, er);
    check({name, " zero"}, {31'd0, zero}, {31'd0, ez});
    check({name, " illegal"}, {31'd0, illegal}, {31'd0, ei});
    @(negedge clk);
    check({name, " idle after handshake"}, {30'd0, out_valid, in_ready}, 32'b01);
  endtask

  logic [3:0]  rc;
  logic [31:0] ra, rb, er;
  int          lat;
  logic        seen;

  initial begin
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    out_ready   = 1'b1;
    alu_control = 4'd0;
    src_a       = '0;
    src_b       = '0;

    // reset held for two edges
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset outputs", {28'd0, out_valid, zero, illegal, 1'b0}, 32'd0);
    check("reset result", result, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("in_ready after reset", {31'd0, in_ready}, 32'd1);

    vecs.push_back('{4'h2, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0, 1});
    vecs.push_back('{4'h6, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0, 1});
    vecs.push_back('{4'h7, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1});
    vecs.push_back('{4'h8, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1});
    vecs.push_back('{4'hC, 32'h80000000, 32'h00000004, 32'hF8000000, 1'b0, 1'b0, 5});
    vecs.push_back('{4'hB, 32'h80000000, 32'h00000004, 32'h08000000, 1'b0, 1'b0, 5});
    vecs.push_back('{4'hA, 32'h00000001, 32'h0000001F, 32'h80000000, 1'b0, 1'b0, 32});
    vecs.push_back('{4'hA, 32'h0000ABCD, 32'h00000020, 32'h0000ABCD, 1'b0, 1'b0, 1});
    vecs.push_back('{4'hF, 32'h12345678, 32'h00000003, 32'h00000000, 1'b1, 1'b1, 1});
    vecs.push_back('{4'h3, 32'h12345678, 32'h00000003, 32'h00000000, 1'b1, 1'b1, 1});
    vecs.push_back('{4'h0, 32'h000000F0, 32'h0000003C, 32'h00000030, 1'b0, 1'b0, 1});
    vecs.push_back('{4'h1, 32'h00000F00, 32'h000000F0, 32'h00000FF0, 1'b0, 1'b0, 1});
    vecs.push_back('{4'h4, 32'h000000A5, 32'h000000FF, 32'h0000005A, 1'b0, 1'b0, 1});
    vecs.push_back('{4'hC, 32'h70000000, 32'h00000003, 32'h0E000000, 1'b0, 1'b0, 4});
    vecs.push_back('{4'hB, 32'h00000001, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 2});

    foreach (vecs[i])
      run_and_check($sformatf("vec%0d", i), vecs[i].ctrl, vecs[i].a, vecs[i].b,
                    vecs[i].res, vecs[i].zero, vecs[i].ill, vecs[i].lat);

    // backpressure: result held for 10 cycles, new ops ignored
    out_ready = 1'b0;
    send(4'h6, 32'd9, 32'd4);
    wait_valid(lat);
    check("bp latency", 32'(lat), 32'd1);
    for (int k = 0; k < 10; k++) begin
      if (k > 0) @(negedge clk);
      check($sformatf("bp hold %0d", k), {result[29:0], out_valid, in_ready}, {30'd5, 1'b1, 1'b0});
      in_valid    = 1'b1;
      alu_control = 4'h2;
      src_a       = 32'd100;
      src_b       = 32'd1;
    end
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(negedge clk);
    check("bp release", {30'd0, out_valid, in_ready}, 32'b01);
    check("bp result kept", result, 32'd5);
    @(negedge clk);
    check("bp no stray accept", {31'd0, out_valid}, 32'd0);

    // reset in the middle of a 20-bit shift
    send(4'hA, 32'd1, 32'd20);
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      seen |= out_valid;
    end
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mid-shift reset state", {28'd0, out_valid, in_ready, zero, illegal}, 32'b0100);
    check("mid-shift reset result", result, 32'd0);
    repeat (30) begin
      @(negedge clk);
      seen |= out_valid;
    end
    check("mid-shift op discarded", {31'd0, seen}, 32'd0);
    run_and_check("after reset and", 4'h0, 32'hF0, 32'h3C, 32'h30, 1'b0, 1'b0, 1);

    // randomized ops against the reference model
    for (int i = 0; i < 150; i++) begin
      rc = 4'($urandom);
      if ($urandom_range(0, 3) == 0) rc = 4'(10 + $urandom_range(0, 2));
      ra = $urandom;
      if ($urandom_range(0, 7) == 0) ra = 32'h80000000 | ra;
      rb = ($urandom_range(0, 2) == 0) ? $urandom : 32'($urandom_range(0, 40));
      if (rc == 4'd6 && $urandom_range(0, 7) == 0) rb = ra;
      er = ref_res(rc, ra, rb);
      run_and_check($sformatf("rand%0d op%0d", i, rc), rc, ra, rb, er, (er == 32'd0),
                    ref_ill(rc), ref_lat(rc, rb));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule

// File: doc/alu_iter.md
# alu_iter

Multi-cycle ALU consuming the 4-bit ALUControl code from the ALU decoder, used in the low-area core variant where the barrel shifter is replaced by a 1-bit-per-cycle shifter. Logic, add/sub and compare ops finish one cycle after acceptance. Shifts take one extra cycle per bit of shift amount. Operands and results move over valid/ready handshakes, so the execute stage stalls for long shifts.

## Interface
- WIDTH, 32: operand/result width; power of two, ≥ 8.
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  operands and op presented.
- in_ready  out  1  unit accepts a new op.
- alu_control  in  4  ALUControl code from the decoder.
- src_a  in  WIDTH  operand A.
- src_b  in  WIDTH  operand B; shift amount is src_b[log2(WIDTH)-1:0].
- out_valid  out  1  result valid.
- out_ready  in  1  consumer takes result.
- result  out  WIDTH  registered result.
- zero  out  1  registered result == 0.
- illegal  out  1  registered; op code was not in the legal set.

## Operation
- Codes: 0000 and, 0001 or, 0010 add, 0100 xor, 0110 sub, 0111 slt (signed), 1000 sltu, 1010 sll, 1011 srl, 1100 sra. All other codes, including 1111, are illegal.
- Illegal op: result = 0, zero = 1, illegal = 1, 1-cycle path.
- Add/sub wrap modulo 2^WIDTH.
- slt and sltu return 1 or 0, zero-extended to WIDTH.
- FSM states:
  - IDLE: in_ready = 1.
  - SHIFT: iterative shift in progress.
  - DONE: out_valid = 1.
- IDLE → DONE: on accept (in_valid & in_ready) with a non-shift op, or a shift with shamt = 0. Result is computed combinationally and registered.
- IDLE → SHIFT: shift op with shamt n > 0. Load shift register = src_a and count = n, and latch the op.
- In SHIFT, one 1-bit shift per cycle:
  - sll: shift left, fill 0.
  - srl: shift right, fill 0.
  - sra: shift right, fill with the original src_a MSB.
  - count decrements each cycle. When count reaches 0, the register holds the final value. State goes to DONE, with zero computed from the final value.
- DONE → IDLE: on out_valid & out_ready. result, zero and illegal hold stable until then.
- in_ready is low in SHIFT and DONE. There is no accept in the same cycle as an output handshake.
- Operands are sampled only at accept. Input changes after accept have no effect.

## Timing
- Op accepted in cycle c:
  - Non-shift, illegal, or shamt 0: out_valid = 1 in cycle c+1.
  - Shift with shamt n: out_valid = 1 in cycle c+1+n. Worst case is WIDTH cycles (n = WIDTH-1).
- Output handshake in cycle d: out_valid = 0 and in_ready = 1 in cycle d+1.
- Throughput: at most one op per 2 cycles with out_ready held high.
- Reset (rst_n low at an edge), with priority over all other events:
  - State = IDLE; outputs out_valid = 0, result = 0, zero = 0, illegal = 0.
  - Reset in SHIFT or DONE discards the op with no output.
  - in_ready = 1 in the first cycle after reset deasserts.
- out_ready is ignored outside DONE. in_valid is ignored outside IDLE.

## Structure
- Shared package alu_pkg holds:
  - alu_ctrl_t: 4-bit enum of the ten codes plus ALU_ILLEGAL = 4'b1111.
  - is_shift(op) helper.
  - The decoder is updated to drive alu_ctrl_t.
- Sub-module alu_comb: purely combinational single-cycle ops and the legal check (and/or/add/sub/xor/slt/sltu, illegal flag).
- Top level holds the FSM, shift register, counter and output registers.

## Test plan
- Reset: hold rst_n low 2 cycles → out_valid = 0, result = 0, zero = 0, illegal = 0; in_ready = 1 after release.
- Simple ops: add 0x7FFFFFFF + 1 → 0x80000000 in cycle c+1. sub 5 - 5 → 0 with zero = 1. slt 0xFFFFFFFF, 1 → 1. sltu 0xFFFFFFFF, 1 → 0.
- Shift timing:
  - sra 0x80000000 by 4 → 0xF8000000, out_valid at c+5.
  - srl same operands → 0x08000000.
  - sll 1 by 31 → 0x80000000 at c+32.
  - Shift by 0 → src_a at c+1.
- Backpressure: hold out_ready low 10 cycles in DONE → result stable, in_ready = 0, new in_valid ignored; release → IDLE next cycle.
- Illegal: code 1111 and code 0011 → result = 0, zero = 1, illegal = 1 at c+1.
- Reset mid-shift: sll by 20, pull rst_n low at cycle c+6 → no out_valid. Next op (and 0xF0, 0x3C → 0x30) completes normally.
